// File: rtl/dense_result_streamer.sv
// dense_result_streamer
//
// Drains a completed dense-layer output vector and presents it one element at
// a time over a valid/ready handshake. While the elements stream out, it keeps a
// signed running maximum. The index of the winning element (the predicted class)
// is reported once the last element has been accepted.
//
// Parameters
//   DATA_W  width of one signed element
//   NUM     elements per vector (>= 2)
//   IDX_W   index width, 2**IDX_W >= NUM
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        single-cycle request to capture vecIn (honoured only when idle)
//   abort        synchronous cancel; takes priority over start
//   vecIn        parallel elements, element i at [i*DATA_W +: DATA_W]
//   busy         high from the capture until the done cycle inclusive
//   outValid     outData/outIdx/outLast hold an element
//   outReady     consumer accepts the current element
//   outData      current element
//   outIdx       index of the current element
//   outLast      current element is the final one
//   done         one-cycle pulse after the last element is transferred
//   argmaxIdx    index of the maximum of the last completed vector
//   argmaxValid  argmaxIdx is meaningful; cleared by the next start or abort

module dense_result_streamer #(
    parameter int DATA_W = 32,
    parameter int NUM    = 10,
    parameter int IDX_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM*DATA_W-1:0] vecIn,
    output logic                  busy,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATA_W-1:0]     outData,
    output logic [IDX_W-1:0]      outIdx,
    output logic                  outLast,
    output logic                  done,
    output logic [IDX_W-1:0]      argmaxIdx,
    output logic                  argmaxValid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t state;
    state_t stateNext;

    logic [DATA_W-1:0] vecBuf [NUM];
    logic [IDX_W-1:0]  cnt;
    logic [IDX_W-1:0]  cntInc;
    logic [DATA_W-1:0] maxVal;
    logic [IDX_W-1:0]  maxIdx;
    logic [DATA_W-1:0] winVal;
    logic [IDX_W-1:0]  winIdx;
    logic              capture;
    logic              xfer;
    logic              lastXfer;

    // The element counter doubles as the presented index, so outIdx is a
    // plain register with no extra copy.
    assign outIdx = cnt;
    assign cntInc = cnt + IDX_W'(1);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic. abort overrides everything, including a start
    // arriving in the same cycle, so it is applied last.
    always_comb begin
        stateNext = state;
        capture   = 1'b0;
        xfer      = 1'b0;
        lastXfer  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    stateNext = STREAM;
                end
            end
            STREAM: begin
                xfer     = outValid && outReady;
                lastXfer = xfer && (cnt == LAST_IDX);
                if (lastXfer) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (abort) begin
            stateNext = IDLE;
            capture   = 1'b0;
            xfer      = 1'b0;
            lastXfer  = 1'b0;
        end
    end

    // Running-max candidate for the element being transferred. outData always
    // equals vecBuf[cnt] while streaming, so it is used directly. Element 0
    // seeds the maximum; afterwards only a strictly greater value replaces it,
    // which leaves ties with the lower index.
    always_comb begin
        winVal = maxVal;
        winIdx = maxIdx;
        if ((cnt == '0) || ($signed(outData) > $signed(maxVal))) begin
            winVal = outData;
            winIdx = cnt;
        end
    end

    // Datapath and registered outputs. Status flags are derived from the
    // next state so they line up with the state they describe, and nothing
    // visible to the consumer depends combinationally on outReady.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM; i++) begin
                vecBuf[i] <= '0;
            end
            cnt         <= '0;
            maxVal      <= '0;
            maxIdx      <= '0;
            outData     <= '0;
            outLast     <= 1'b0;
            outValid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            argmaxIdx   <= '0;
            argmaxValid <= 1'b0;
        end else begin
            outValid <= (stateNext == STREAM);
            busy     <= (stateNext != IDLE);
            done     <= (stateNext == DONE);

            if (capture) begin
                for (int i = 0; i < NUM; i++) begin
                    vecBuf[i] <= vecIn[i*DATA_W +: DATA_W];
                end
                cnt         <= '0;
                outData     <= vecIn[DATA_W-1:0];
                outLast     <= (LAST_IDX == '0);
                argmaxValid <= 1'b0;
            end else if (xfer) begin
                maxVal <= winVal;
                maxIdx <= winIdx;
                if (lastXfer) begin
                    argmaxIdx   <= winIdx;
                    argmaxValid <= 1'b1;
                    outLast     <= 1'b0;
                end else begin
                    cnt     <= cntInc;
                    outData <= vecBuf[cntInc];
                    outLast <= (cntInc == LAST_IDX);
                end
            end

            if (abort) begin
                argmaxValid <= 1'b0;
                outLast     <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dense_result_streamer.md
# dense_result_streamer

Drains a completed dense-layer output vector and presents it to downstream logic one element per transfer over a valid/ready handshake. While streaming, it tracks the signed maximum and reports the winning index, which is the predicted MNIST class. It sits between the dense accumulator registers (parallel write side) and the result consumer (AXI-stream adapter or classifier readout).

## Interface
- DATA_W, 32, width of one dense output element, signed two's complement
- NUM, 10, number of elements per vector (≥2)
- IDX_W, 4, index width, must satisfy 2^IDX_W ≥ NUM
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset: asserting low immediately clears all state
- start  in  1  single-cycle request to capture vecIn and begin streaming
- abort  in  1  synchronous cancel of the current operation
- vecIn  in  NUM*DATA_W  parallel dense outputs; element i occupies bits [i*DATA_W +: DATA_W]
- busy  out  1  high from capture until the operation completes
- outValid  out  1  outData/outIdx/outLast hold a valid element
- outReady  in  1  consumer accepts the element this cycle
- outData  out  DATA_W  current element
- outIdx  out  IDX_W  index of the current element
- outLast  out  1  current element is index NUM-1
- done  out  1  single-cycle pulse after the last element is transferred
- argmaxIdx  out  IDX_W  index of the maximum element of the last completed vector
- argmaxValid  out  1  argmaxIdx is valid; held until the next start or abort

## Operation
- The FSM has three states: IDLE, STREAM and DONE.
- IDLE: when start=1 and abort=0, latch all of vecIn into an internal buffer, set the element counter to 0, clear argmaxValid, and go to STREAM. start is ignored in every other state.
- STREAM: outValid=1, outData=buf[cnt], outIdx=cnt, outLast=(cnt==NUM-1).
  - A transfer occurs on a cycle where outValid and outReady are both 1.
  - On each transfer, update the running max and its index, using a signed compare with a strictly-greater rule, so the lowest index wins ties. Element 0 initialises the running max unconditionally.
  - Transfer with cnt<NUM-1: increment cnt.
  - Transfer with cnt==NUM-1: go to DONE and load argmaxIdx from the running max index.
  - With no transfer, all out* signals are held stable.
- DONE: done=1, argmaxValid=1, busy=1, outValid=0, for exactly one cycle. Then go to IDLE.
- argmaxValid stays 1 in IDLE until the next accepted start or abort.
- abort=1 in any state: the next state is IDLE and outValid, busy and argmaxValid all go to 0. An in-flight vector is discarded, and no done pulse is generated. If abort and start arrive in the same cycle, abort wins and start is dropped.
- vecIn is sampled only in the capture cycle. Later changes to vecIn do not affect the vector being streamed.
- Reset values:
  - state=IDLE, cnt=0.
  - busy, outValid, outLast, done and argmaxValid are 0.
  - outData, outIdx and argmaxIdx are all-zero.
- If reset is asserted mid-stream, all outputs go to their reset values immediately (asynchronously). No done pulse is produced.

## Timing
- start sampled at edge 0 → outValid=1 with element 0 after edge 1, i.e. 1 cycle of latency.
- With outReady held high, element k is presented in cycle 1+k, outLast in cycle NUM, done and argmaxValid in cycle NUM+1, and busy=0 from cycle NUM+2.
- A new start is accepted in cycle NUM+2 at the earliest, giving a throughput of NUM+2 cycles per vector.
- Each stall cycle with outReady=0 adds exactly one cycle. outData is never changed while outValid=1 and outReady=0.
- done and argmaxValid rise in the same cycle. argmaxIdx is stable from that cycle onward.
- outputs are registered; there is no combinational path from outReady to outValid.

## Test plan
- Reset, then stream vector {5,-3,12,7,0,1,2,3,4,11} with outReady=1 → elements at cycles 1–10 with outIdx 0–9, outLast only at idx 9, done at cycle 11, argmaxIdx=2, argmaxValid=1.
- Same vector with outReady toggling 1,0,1,0,… → every element appears once in order, data is stable during stalls, done at cycle 20, argmaxIdx=2.
- All-negative vector with a tie, {-8,-2,-9,-2,…,-100} → argmaxIdx=1 (lowest index wins); the signed compare must not choose -100.
- start pulsed during STREAM, and vecIn changed after capture → both ignored; the original data streams out and the original argmax is reported.
- abort asserted at element 4, and in a separate case abort+start together in IDLE → next cycle outValid=0, busy=0, argmaxValid=0, no done pulse; no capture in the abort+start case.
- rst driven low mid-stream at element 6 → all outputs go to reset values immediately; after release, a fresh start streams correctly from idx 0.
